pwm_pattern_seq: RTL and testbench
==================================

Name: pwm_pattern_seq

Overview:
- Multi-channel, table-driven ON/OFF pattern generator for LED and indicator pins.
- A shared prescaler divides `clk` into a time-base tick.
- Each channel steps through a run-time programmable list of (level, duration-in-ticks) entries and wraps at a marked last step.
- Generalises the fixed 1/2/3-second pattern to N channels, programmable sequences, configurable tick period and a clean enable/reset.

Parameters:
- NUM_CH, 3, number of independent output channels (1..16)
- TICK_DIV, 27000000, clk cycles per time-base tick (≥2); 27 MHz gives 1 s
- MAX_STEPS, 8, table entries per channel (power of 2, ≥2)
- DUR_W, 4, width of per-step duration field in ticks
- CH_W, $clog2(NUM_CH) (min 1), width of `cfg_ch`
- STEP_W, $clog2(MAX_STEPS), width of `cfg_step`

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run control; 0 holds all channels idle
- cfg_we  in  1  table write strobe, one entry per cycle
- cfg_ch  in  CH_W  channel to write
- cfg_step  in  STEP_W  step index to write
- cfg_level  in  1  output level for the step
- cfg_dur  in  DUR_W  step duration in ticks; 0 is treated as 1
- cfg_last  in  1  step is last in its sequence (wrap to step 0 after it)
- tick  out  1  one-cycle pulse per time-base tick
- pwm_out  out  NUM_CH  registered channel outputs
- cycle_done  out  NUM_CH  one-cycle pulse when a channel wraps to step 0

Behaviour:
- Reset, asynchronous, any time including mid-pattern:
  - prescaler = 0, tick = 0, pwm_out = 0, cycle_done = 0.
  - All channels: step pointer = 0.
  - Every table entry = {level 0, dur 1, last 0}, except step 0 of every channel, which has last = 1.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while enable = 1.
  - `tick` is asserted in the cycle the count equals TICK_DIV-1; the count then returns to 0.
  - enable = 0 clears the count to 0 synchronously.
- Per-channel state: step pointer `ptr` and remaining count `rem` (DUR_W bits). The current entry's level and last flag are latched into channel state when a step is loaded.
- Step load:
  - Sets rem = max(dur, 1) and latches level and last from `table[ch][ptr]`.
  - Reads the table contents as they were before any same-cycle cfg write (read-before-write).
- Idle (enable = 0):
  - ptr = 0, step 0 continuously reloaded, pwm_out = 0, cycle_done = 0.
- Run (enable = 1), on each tick:
  - If rem > 1: rem decrements.
  - If rem == 1: the channel advances.
    - If the latched last = 1, or ptr == MAX_STEPS-1: ptr = 0, step 0 is loaded, and cycle_done[ch] pulses in the following cycle.
    - Otherwise ptr = ptr+1 and that step is loaded.
  - All channels advance on the same tick, independently.
- Output: pwm_out[ch] <= enable ? latched level : 0. Registered, so one clk of latency from enable or a step load.
- First enabled cycle: pwm_out shows step 0 level in the next cycle. Step 0 lasts its dur ticks counted from the first tick, so its first tick period is full (TICK_DIV clocks).
- Config writes:
  - Accepted any cycle, including while running.
  - The entry is updated at the clock edge; cfg_dur = 0 is stored as-is.
  - A write to the currently active step does not alter its rem or latched level; it takes effect on the next visit.
  - cfg_ch ≥ NUM_CH: the write is ignored.
- enable falling mid-step: the channel returns to idle next cycle, and pwm_out = 0 from the following cycle. Re-enabling restarts from step 0, with no resume.
- A sequence with no last flag set runs through all MAX_STEPS entries, then wraps.
- Period of a channel = sum of max(dur,1) over steps 0..last, in ticks.

Test Plan:
- Reset values: assert rst_n = 0 mid-run with TICK_DIV = 4 → pwm_out, cycle_done and tick go to 0 immediately; after release with enable = 1, all channels are low; cycle_done pulses every 4 clk (default step 0: level 0, dur 1, last 1).
- Legacy pattern: TICK_DIV = 4; ch0 steps 0..5 = (1,1),(0,1),(1,2),(0,1),(1,3),(0,1), last on step 5 → pwm_out[0] high 4 / low 4 / high 8 / low 4 / high 12 / low 4 clk; cycle_done[0] every 36 clk.
- Independent channels:
  - ch1 = (1,2),(0,2) last → 50% duty over 16 clk.
  - ch2 = (1,0) last → dur 0 treated as 1; held high, cycle_done[2] every 4 clk.
  - ch0 runs unaffected.
- No last flag: all 8 steps dur 1, alternating levels → wraps after step 7; cycle_done every 32 clk.
- Live rewrite: write a new level to ch0 step 2 while step 2 is active → the current step is unchanged; the new level appears on the next pass. A write with cfg_ch = 3 (NUM_CH = 3) changes nothing.
- Enable toggle: drop enable mid step 4 → pwm_out = 0 one cycle later; re-assert → pattern restarts at step 0 with a full first tick.

Source files
------------

// File: rtl/pwm_pattern_seq_if.sv
`default_nettype none
// ============================================================================
// Module : pwm_pattern_seq_if
// Brief  : Run control, pattern-table write port and outputs of pwm_pattern_seq
// Rev    : 1.0
// ============================================================================
interface pwm_pattern_seq_if #(
  parameter int NUM_CH = 3,
  parameter int CH_W   = 2,
  parameter int STEP_W = 3,
  parameter int DUR_W  = 4
);
  logic              enable;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [STEP_W-1:0] cfg_step;
  logic              cfg_level;
  logic [DUR_W-1:0]  cfg_dur;
  logic              cfg_last;
  logic              tick;
  logic [NUM_CH-1:0] pwm_out;
  logic [NUM_CH-1:0] cycle_done;

  modport master (
    output enable, cfg_we, cfg_ch, cfg_step, cfg_level, cfg_dur, cfg_last,
    input  tick, pwm_out, cycle_done
  );

  modport slave (
    input  enable, cfg_we, cfg_ch, cfg_step, cfg_level, cfg_dur, cfg_last,
    output tick, pwm_out, cycle_done
  );
endinterface
`default_nettype wire

// File: rtl/pwm_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module : pwm_pattern_seq
// Brief  : N-channel table-driven ON/OFF pattern generator on a shared tick
// Rev    : 1.0
// ============================================================================
module pwm_pattern_seq #(
  parameter int NUM_CH    = 3,
  parameter int TICK_DIV  = 27000000,
  parameter int MAX_STEPS = 8,
  parameter int DUR_W     = 4,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int STEP_W    = $clog2(MAX_STEPS)
) (
  input logic              clk,
  input logic              rst_n,
  pwm_pattern_seq_if.slave bus
);
  localparam int                 c_PS_W     = $clog2(TICK_DIV);
  localparam logic [c_PS_W-1:0]  c_PS_MAX   = c_PS_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0]  c_STEP_MAX = STEP_W'(MAX_STEPS - 1);

  logic [c_PS_W-1:0] r_ps;
  logic              w_tick;
  logic [NUM_CH-1:0] w_pwm;
  logic [NUM_CH-1:0] w_cd;

  assign w_tick = bus.enable && (r_ps == c_PS_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ps <= '0;
    end else if (!bus.enable || w_tick) begin
      r_ps <= '0;
    end else begin
      r_ps <= r_ps + c_PS_W'(1);
    end
  end

  genvar g;
  for (g = 0; g < NUM_CH; g++) begin : g_ch
    logic              r_tlvl  [MAX_STEPS];
    logic [DUR_W-1:0]  r_tdur  [MAX_STEPS];
    logic              r_tlast [MAX_STEPS];
    logic [STEP_W-1:0] r_ptr;
    logic [DUR_W-1:0]  r_rem;
    logic              r_lvl;
    logic              r_last;
    logic              r_pwm;
    logic              r_cd;
    logic              w_adv;
    logic              w_wrap;
    logic              w_ld;
    logic              w_wr;
    logic [STEP_W-1:0] w_nptr;
    logic [STEP_W-1:0] w_ld_idx;

    assign w_adv    = w_tick && (r_rem <= DUR_W'(1));
    assign w_wrap   = r_last || (r_ptr == c_STEP_MAX);
    assign w_nptr   = w_wrap ? '0 : r_ptr + STEP_W'(1);
    // Idle continuously reloads step 0 so the first enabled cycle starts clean.
    assign w_ld     = !bus.enable || w_adv;
    assign w_ld_idx = bus.enable ? w_nptr : '0;
    assign w_wr     = bus.cfg_we && (bus.cfg_ch == CH_W'(g));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ptr  <= '0;
        r_rem  <= DUR_W'(1);
        r_lvl  <= 1'b0;
        r_last <= 1'b1;
        r_pwm  <= 1'b0;
        r_cd   <= 1'b0;
      end else begin
        r_pwm <= bus.enable & r_lvl;
        r_cd  <= w_adv & w_wrap;
        if (w_ld) begin
          r_ptr  <= w_ld_idx;
          r_rem  <= (r_tdur[w_ld_idx] == '0) ? DUR_W'(1) : r_tdur[w_ld_idx];
          r_lvl  <= r_tlvl[w_ld_idx];
          r_last <= r_tlast[w_ld_idx];
        end else if (w_tick) begin
          r_rem <= r_rem - DUR_W'(1);
        end
      end
    end

    // Table reads above see pre-write contents; a same-cycle write lands after.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < MAX_STEPS; s++) begin
          r_tlvl[s]  <= 1'b0;
          r_tdur[s]  <= DUR_W'(1);
          r_tlast[s] <= (s == 0);
        end
      end else if (w_wr) begin
        r_tlvl[bus.cfg_step]  <= bus.cfg_level;
        r_tdur[bus.cfg_step]  <= bus.cfg_dur;
        r_tlast[bus.cfg_step] <= bus.cfg_last;
      end
    end

    assign w_pwm[g] = r_pwm;
    assign w_cd[g]  = r_cd;
  end

  assign bus.tick       = w_tick;
  assign bus.pwm_out    = w_pwm;
  assign bus.cycle_done = w_cd;
endmodule
`default_nettype wire

// File: tb/tb_pwm_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_pwm_pattern_seq
// Brief  : Randomised and directed bench for pwm_pattern_seq with a timeline model
// Rev    : 1.0
// ============================================================================
module tb_pwm_pattern_seq;
  localparam int NUM_CH = 3;
  localparam int TD     = 4;
  localparam int MS     = 8;
  localparam int DUR_W  = 4;
  localparam int CH_W   = 2;
  localparam int STEP_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pwm_pattern_seq_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .STEP_W(STEP_W), .DUR_W(DUR_W)) bus ();

  pwm_pattern_seq #(
    .NUM_CH(NUM_CH), .TICK_DIV(TD), .MAX_STEPS(MS), .DUR_W(DUR_W),
    .CH_W(CH_W), .STEP_W(STEP_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference: mirrored tables plus, per channel, which step is playing and
  // how many ticks of it have elapsed.
  logic              t_lvl  [NUM_CH][MS];
  int                t_dur  [NUM_CH][MS];
  logic              t_last [NUM_CH][MS];
  int                m_step [NUM_CH];
  int                m_el   [NUM_CH];
  int                m_dur  [NUM_CH];
  logic              m_lvl  [NUM_CH];
  logic              m_lst  [NUM_CH];
  logic [NUM_CH-1:0] m_pwm;
  logic [NUM_CH-1:0] m_cd;
  int                m_run;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void mload(int c, int s);
    m_step[c] = s;
    m_el[c]   = 0;
    m_lvl[c]  = t_lvl[c][s];
    m_dur[c]  = (t_dur[c][s] == 0) ? 1 : t_dur[c][s];
    m_lst[c]  = t_last[c][s];
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < MS; s++) begin
        t_lvl[c][s]  = 1'b0;
        t_dur[c][s]  = 1;
        t_last[c][s] = (s == 0);
      end
      mload(c, 0);
    end
    m_pwm = '0;
    m_cd  = '0;
    m_run = 0;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        bit tk;
        tk = bus.enable && ((m_run % TD) == TD - 1);
        for (int c = 0; c < NUM_CH; c++) begin
          m_pwm[c] = bus.enable ? m_lvl[c] : 1'b0;
          m_cd[c]  = 1'b0;
          if (!bus.enable) begin
            mload(c, 0);
          end else if (tk) begin
            m_el[c]++;
            if (m_el[c] >= m_dur[c]) begin
              bit w;
              w = m_lst[c] || (m_step[c] == MS - 1);
              m_cd[c] = w;
              mload(c, w ? 0 : m_step[c] + 1);
            end
          end
        end
        m_run = bus.enable ? m_run + 1 : 0;
        if (bus.cfg_we && (int'(bus.cfg_ch) < NUM_CH)) begin
          t_lvl[bus.cfg_ch][bus.cfg_step]  = bus.cfg_level;
          t_dur[bus.cfg_ch][bus.cfg_step]  = int'(bus.cfg_dur);
          t_last[bus.cfg_ch][bus.cfg_step] = bus.cfg_last;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("pwm_out", 64'(bus.pwm_out), 64'(m_pwm));
        chk("cycle_done", 64'(bus.cycle_done), 64'(m_cd));
        chk("tick", 64'(bus.tick), 64'(bus.enable && ((m_run % TD) == TD - 1)));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(int ch, int st, bit lvl, int dur, bit last);
    bus.cfg_we    = 1'b1;
    bus.cfg_ch    = CH_W'(ch);
    bus.cfg_step  = STEP_W'(st);
    bus.cfg_level = lvl;
    bus.cfg_dur   = DUR_W'(dur);
    bus.cfg_last  = last;
    cyc(1);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic wait_step(int c, int s);
    int n = 0;
    while (m_step[c] != s && n < 400) begin
      cyc(1);
      n++;
    end
    chk("wait_step_reached", 64'(m_step[c]), 64'(s));
  endtask

  task automatic wait_cd(int c, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 400) begin
      @(negedge clk);
      if (bus.cycle_done[c]) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
  endtask

  task automatic measure_period(string nm, int c, int exp);
    bit ok;
    int n = 0;
    wait_cd(c, ok);
    if (ok) begin
      do begin
        @(negedge clk);
        n++;
      end while (!bus.cycle_done[c] && n < 400);
    end else begin
      n = -1;
    end
    chk(nm, 64'(n), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic capture_wave(int c, int len, output logic [63:0] v);
    bit ok;
    v = '0;
    wait_cd(c, ok);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      v[i] = bus.pwm_out[c] & ok;
    end
    @(posedge clk);
    #1;
  endtask

  int          L_LVL [6] = '{1, 0, 1, 0, 1, 0};
  int          L_DUR [6] = '{1, 1, 2, 1, 3, 1};
  logic [63:0] v;
  logic [63:0] ev;

  initial begin
    bus.enable = 1'b0; bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_step = '0;
    bus.cfg_level = 1'b0; bus.cfg_dur = '0; bus.cfg_last = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    bus.enable = 1'b1;
    cyc(10);

    // Asynchronous reset in the middle of a clock period.
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_pwm", 64'(bus.pwm_out), 64'd0);
    chk("rst_cd", 64'(bus.cycle_done), 64'd0);
    chk("rst_tick", 64'(bus.tick), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    measure_period("default_period", 0, 4);
    chk("default_low", 64'(bus.pwm_out), 64'd0);

    // Legacy pattern on ch0 plus two independent channels.
    bus.enable = 1'b0;
    for (int s = 0; s < 6; s++) wr(0, s, L_LVL[s][0], L_DUR[s], s == 5);
    wr(1, 0, 1'b1, 2, 1'b0);
    wr(1, 1, 1'b0, 2, 1'b1);
    wr(2, 0, 1'b1, 0, 1'b1);
    cyc(2);
    bus.enable = 1'b1;
    ev = '0;
    begin
      int idx = 0;
      for (int s = 0; s < 6; s++)
        for (int k = 0; k < L_DUR[s] * TD; k++) begin
          ev[idx] = L_LVL[s][0];
          idx++;
        end
    end
    capture_wave(0, 36, v);
    chk("legacy_wave", v, ev);
    measure_period("legacy_period", 0, 36);
    capture_wave(1, 16, v);
    chk("ch1_wave", v, 64'h00FF);
    measure_period("ch1_period", 1, 16);
    capture_wave(2, 16, v);
    chk("ch2_high", v, 64'hFFFF);
    measure_period("ch2_period", 2, 4);

    // Rewrite of the active step only shows on the next pass.
    wait_step(0, 2);
    wr(0, 2, 1'b0, 2, 1'b0);
    wr(3, 2, 1'b0, 5, 1'b1);
    @(negedge clk);
    chk("live_keep", 64'(bus.pwm_out[0]), 64'd1);
    @(posedge clk);
    #1;
    wait_step(0, 3);
    wait_step(0, 2);
    cyc(1);
    @(negedge clk);
    chk("live_next", 64'(bus.pwm_out[0]), 64'd0);
    @(posedge clk);
    #1;
    wr(0, 2, 1'b1, 2, 1'b0);

    // Drop enable in step 4, then restart from step 0 with a full first tick.
    wait_step(0, 4);
    cyc(2);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("en_drop_hold", 64'(bus.pwm_out[0]), 64'd1);
    @(negedge clk);
    chk("en_drop_zero", 64'(bus.pwm_out[0]), 64'd0);
    @(posedge clk);
    #1;
    cyc(3);
    bus.enable = 1'b1;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v[i] = bus.tick;
    end
    chk("first_tick", v, 64'b1000);
    @(posedge clk);
    #1;
    measure_period("restart_period", 0, 36);

    // No last flag anywhere: all eight steps play before the wrap.
    bus.enable = 1'b0;
    for (int s = 0; s < MS; s++) wr(0, s, (s % 2) == 0, 1, 1'b0);
    bus.enable = 1'b1;
    measure_period("nolast_period", 0, 32);

    // Random writes (including the out-of-range channel) and enable toggles.
    repeat (2500) begin
      if ($urandom_range(0, 99) < 30) begin
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = CH_W'($urandom_range(0, 3));
        bus.cfg_step  = STEP_W'($urandom_range(0, MS - 1));
        bus.cfg_level = 1'($urandom_range(0, 1));
        bus.cfg_dur   = DUR_W'($urandom_range(0, 15));
        bus.cfg_last  = ($urandom_range(0, 3) == 0);
      end else begin
        bus.cfg_we = 1'b0;
      end
      if ($urandom_range(0, 199) == 0) bus.enable = ~bus.enable;
      cyc(1);
    end
    bus.cfg_we = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
